wb_writeback_unit: RTL and testbench

Writeback stage that consumes the MEM/WB pipeline register outputs and produces the register-file write port (`wb_write`, `wb_write_reg`, `wb_write_data`), which also feeds back into the MEM/WB register as the forwarding path. It selects ALU result or load data and stalls upstream via a ready handshake while a load's memory data is outstanding. It also counts retired instructions per core.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_load_extract.sv | 37 +++
 rtl/wb_writeback_unit.sv | 121 ++++++++++++
 tb/tb_wb_writeback_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding and
// load-size codes carried on wb_load_size.
package wb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/wb_load_extract.sv
// Little-endian sub-word load extraction with sign/zero extension when
// WB_LOAD_EXTEND_EN is defined; a plain word passthrough otherwise.
module wb_load_extract
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] result
);

`ifdef WB_LOAD_EXTEND_EN
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // offset[0] is ignored for halves: misaligned halves read the aligned pair.
    assign lane_byte = data[{offset, 3'b000} +: 8];
    assign lane_half = data[{offset[1], 4'b0000} +: 16];

    always_comb begin
        result = data;
        case (size)
            LS_BYTE: result = {{(DATA_WIDTH-8){~is_unsigned & lane_byte[7]}}, lane_byte};
            LS_HALF: result = {{(DATA_WIDTH-16){~is_unsigned & lane_half[15]}}, lane_half};
            default: result = data;
        endcase
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{size, offset, is_unsigned};
    assign result     = data;
`endif

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: selects ALU or load data, stalls on outstanding load data,
// counts retired instructions. Optional sub-word loads via WB_LOAD_EXTEND_EN.
module wb_writeback_unit
    import wb_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic                  wb_regWrite,
    input  logic                  wb_memRead,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_ALU_result,
    input  logic [DATA_WIDTH-1:0] wb_memory_data,
    input  logic                  wb_mem_data_valid,
    input  logic [1:0]            wb_load_size,
    input  logic                  wb_load_unsigned,
    output logic                  wb_write,
    output logic [4:0]            wb_write_reg,
    output logic [DATA_WIDTH-1:0] wb_write_data,
    output logic [31:0]           retired_count
);

    localparam int core_id_unused   = CORE;
    localparam int addr_bits_unused = ADDRESS_BITS;

    wb_state_e state, state_next;

    logic       hold_regwrite, hold_unsigned;
    logic [4:0] hold_rd;
    logic [1:0] hold_offset, hold_size;

    logic       complete, capture, sel_held;
    logic       cur_regwrite, cur_is_load, cur_unsigned;
    logic [4:0] cur_rd;
    logic [1:0] cur_offset, cur_size;
    logic [DATA_WIDTH-1:0] load_data, cur_data;

    // Handshake: a slot transfers on a clock edge where wb_valid && wb_ready;
    // wb_ready depends on state only, and upstream holds MEM/WB while it is low.
    assign wb_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        capture    = 1'b0;
        sel_held   = 1'b0;
        case (state)
            IDLE: begin
                if (wb_valid) begin
                    if (wb_memRead && !wb_mem_data_valid) begin
                        capture    = 1'b1;
                        state_next = LOAD_WAIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (wb_mem_data_valid) begin
                    complete   = 1'b1;
                    sel_held   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cur_rd       = sel_held ? hold_rd       : wb_rd;
    assign cur_regwrite = sel_held ? hold_regwrite : wb_regWrite;
    assign cur_is_load  = sel_held | wb_memRead;
    assign cur_offset   = sel_held ? hold_offset   : wb_ALU_result[1:0];
    assign cur_size     = sel_held ? hold_size     : wb_load_size;
    assign cur_unsigned = sel_held ? hold_unsigned : wb_load_unsigned;

    wb_load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .data        (wb_memory_data),
        .size        (cur_size),
        .offset      (cur_offset),
        .is_unsigned (cur_unsigned),
        .result      (load_data)
    );

    assign cur_data = cur_is_load ? load_data : wb_ALU_result;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wb_write      <= 1'b0;
            wb_write_reg  <= 5'd0;
            wb_write_data <= '0;
            retired_count <= 32'd0;
            hold_regwrite <= 1'b0;
            hold_unsigned <= 1'b0;
            hold_rd       <= 5'd0;
            hold_offset   <= 2'd0;
            hold_size     <= 2'd0;
        end else begin
            state    <= state_next;
            wb_write <= complete && cur_regwrite && (cur_rd != 5'd0);
            if (complete && cur_regwrite && (cur_rd != 5'd0)) begin
                wb_write_reg  <= cur_rd;
                wb_write_data <= cur_data;
            end
            if (complete) retired_count <= retired_count + 32'd1;
            if (capture) begin
                hold_regwrite <= wb_regWrite;
                hold_unsigned <= wb_load_unsigned;
                hold_rd       <= wb_rd;
                hold_offset   <= wb_ALU_result[1:0];
                hold_size     <= wb_load_size;
            end
        end
    end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit; expected load values follow WB_LOAD_EXTEND_EN.
module tb_wb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic        wb_regWrite = 1'b0;
    logic        wb_memRead = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_ALU_result = 32'd0;
    logic [31:0] wb_memory_data = 32'd0;
    logic        wb_mem_data_valid = 1'b0;
    logic [1:0]  wb_load_size = 2'b10;
    logic        wb_load_unsigned = 1'b0;
    logic        wb_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [31:0] retired_count;

    int checks = 0;
    int failures = 0;

    wb_writeback_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock             (clock),
        .reset             (reset),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_regWrite       (wb_regWrite),
        .wb_memRead        (wb_memRead),
        .wb_rd             (wb_rd),
        .wb_ALU_result     (wb_ALU_result),
        .wb_memory_data    (wb_memory_data),
        .wb_mem_data_valid (wb_mem_data_valid),
        .wb_load_size      (wb_load_size),
        .wb_load_unsigned  (wb_load_unsigned),
        .wb_write          (wb_write),
        .wb_write_reg      (wb_write_reg),
        .wb_write_data     (wb_write_data),
        .retired_count     (retired_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog sim_time_exceeded got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks: inputs change on negedge, outputs sampled on the next negedge
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_idle();
        wb_valid = 1'b0; wb_regWrite = 1'b0; wb_memRead = 1'b0; wb_rd = 5'd0;
        wb_ALU_result = 32'd0; wb_memory_data = 32'd0; wb_mem_data_valid = 1'b0;
        wb_load_size = 2'b10; wb_load_unsigned = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] alu, input logic rw);
        wb_valid = 1'b1; wb_regWrite = rw; wb_memRead = 1'b0; wb_rd = rd;
        wb_ALU_result = alu; wb_mem_data_valid = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic dvalid, input logic [31:0] data);
        wb_valid = 1'b1; wb_regWrite = 1'b1; wb_memRead = 1'b1; wb_rd = rd;
        wb_ALU_result = addr; wb_load_size = size; wb_load_unsigned = uns;
        wb_mem_data_valid = dvalid; wb_memory_data = data;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", wb_ready); end
        checks++; if (wb_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%0b exp=0", wb_write); end
        checks++; if (wb_write_reg !== 5'd0) begin failures++; $display("FAIL reset_reg got=%0d exp=0", wb_write_reg); end
        checks++; if (wb_write_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%08h exp=0", wb_write_data); end
        checks++; if (retired_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
    endtask

    task automatic test_alu_write();
        drive_alu(5'd5, 32'h0000_1234, 1'b1);
        tick();
        drive_idle();
        checks++; if (wb_write !== 1'b1) begin failures++; $display("FAIL alu_write got=%0b exp=1", wb_write); end
        checks++; if (wb_write_reg !== 5'd5) begin failures++; $display("FAIL alu_reg got=%0d exp=5", wb_write_reg); end
        checks++; if (wb_write_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_data got=%08h exp=00001234", wb_write_data); end
        checks++; if (retired_count !== 32'd1) begin failures++; $display("FAIL alu_count got=%0d exp=1", retired_count); end
        tick();
        checks++; if (wb_write !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%0b exp=0", wb_write); end
        checks++; if (wb_write_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_hold got=%08h exp=00001234", wb_write_data); end
        // stray data_valid in IDLE without a slot must do nothing
        wb_mem_data_valid = 1'b1; wb_memory_data = 32'h5555_5555;
        tick();
        drive_idle();
        checks++; if (wb_write !== 1'b0 || retired_count !== 32'd1) begin failures++; $display("FAIL stray_dvalid write=%0b count=%0d exp write=0 count=1", wb_write, retired_count); end
    endtask

    task automatic test_r0_write();
        drive_alu(5'd0, 32'h0000_ABCD, 1'b1);
        tick();
        drive_idle();
        checks++; if (wb_write !== 1'b0) begin failures++; $display("FAIL r0_write got=%0b exp=0", wb_write); end
        checks++; if (retired_count !== 32'd2) begin failures++; $display("FAIL r0_count got=%0d exp=2", retired_count); end
        checks++; if (wb_write_reg !== 5'd5 || wb_write_data !== 32'h0000_1234) begin failures++; $display("FAIL r0_hold reg=%0d data=%08h exp reg=5 data=00001234", wb_write_reg, wb_write_data); end
    endtask

    task automatic test_load_miss();
        drive_load(5'd7, 32'h0000_0100, 2'b10, 1'b0, 1'b0, 32'd0);
        tick();
        // next instruction held on the slot while the load is outstanding
        drive_alu(5'd9, 32'h0000_9999, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL miss_ready cyc=%0d got=%0b exp=0", i, wb_ready); end
            checks++; if (wb_write !== 1'b0 || retired_count !== 32'd2) begin failures++; $display("FAIL miss_stall cyc=%0d write=%0b count=%0d exp write=0 count=2", i, wb_write, retired_count); end
            if (i == 2) begin wb_mem_data_valid = 1'b1; wb_memory_data = 32'hDEAD_BEEF; end
            tick();
        end
        wb_mem_data_valid = 1'b0; wb_memory_data = 32'd0;
        checks++; if (wb_write !== 1'b1 || wb_write_reg !== 5'd7) begin failures++; $display("FAIL miss_write write=%0b reg=%0d exp write=1 reg=7", wb_write, wb_write_reg); end
        checks++; if (wb_write_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL miss_data got=%08h exp=deadbeef", wb_write_data); end
        checks++; if (wb_ready !== 1'b1 || retired_count !== 32'd3) begin failures++; $display("FAIL miss_exit ready=%0b count=%0d exp ready=1 count=3", wb_ready, retired_count); end
        tick();
        drive_idle();
        checks++; if (wb_write !== 1'b1 || wb_write_reg !== 5'd9 || wb_write_data !== 32'h0000_9999) begin failures++; $display("FAIL miss_next write=%0b reg=%0d data=%08h exp 1/9/00009999", wb_write, wb_write_reg, wb_write_data); end
        checks++; if (retired_count !== 32'd4) begin failures++; $display("FAIL miss_next_count got=%0d exp=4", retired_count); end
    endtask

    task automatic test_extension();
        logic [31:0] exp_sb, exp_ub, exp_sh, exp_held;
`ifdef WB_LOAD_EXTEND_EN
        exp_sb = 32'hFFFF_FF80; exp_ub = 32'h0000_0080; exp_sh = 32'hFFFF_80FF; exp_held = 32'hFFFF_FF9A;
`else
        exp_sb = 32'h80FF_0000; exp_ub = 32'h80FF_0000; exp_sh = 32'h80FF_0000; exp_held = 32'h0000_9A00;
`endif
        drive_load(5'd10, 32'h0000_0003, 2'b00, 1'b0, 1'b1, 32'h80FF_0000);
        tick();
        checks++; if (wb_write !== 1'b1 || wb_write_data !== exp_sb) begin failures++; $display("FAIL ext_byte_signed write=%0b data=%08h exp 1/%08h", wb_write, wb_write_data, exp_sb); end
        drive_load(5'd11, 32'h0000_0003, 2'b00, 1'b1, 1'b1, 32'h80FF_0000);
        tick();
        checks++; if (wb_write_data !== exp_ub || wb_write_reg !== 5'd11) begin failures++; $display("FAIL ext_byte_unsigned data=%08h reg=%0d exp %08h/11", wb_write_data, wb_write_reg, exp_ub); end
        drive_load(5'd12, 32'h0000_0002, 2'b01, 1'b0, 1'b1, 32'h80FF_0000);
        tick();
        checks++; if (wb_write_data !== exp_sh) begin failures++; $display("FAIL ext_half_signed got=%08h exp=%08h", wb_write_data, exp_sh); end
        drive_load(5'd13, 32'h0000_0002, 2'b10, 1'b1, 1'b1, 32'h80FF_0000);
        tick();
        checks++; if (wb_write_data !== 32'h80FF_0000) begin failures++; $display("FAIL ext_word got=%08h exp=80ff0000", wb_write_data); end
        // miss path uses the captured offset/size/unsigned, not the live slot
        drive_load(5'd14, 32'h0000_0001, 2'b00, 1'b0, 1'b0, 32'd0);
        tick();
        wb_ALU_result = 32'h0000_0002; wb_load_size = 2'b10; wb_load_unsigned = 1'b1;
        wb_mem_data_valid = 1'b1; wb_memory_data = 32'h0000_9A00;
        tick();
        drive_idle();
        checks++; if (wb_write !== 1'b1 || wb_write_reg !== 5'd14 || wb_write_data !== exp_held) begin failures++; $display("FAIL ext_held write=%0b reg=%0d data=%08h exp 1/14/%08h", wb_write, wb_write_reg, wb_write_data, exp_held); end
        checks++; if (retired_count !== 32'd9) begin failures++; $display("FAIL ext_count got=%0d exp=9", retired_count); end
    endtask

    task automatic test_reset_mid_wait();
        drive_load(5'd12, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 32'd0);
        tick();
        drive_idle();
        checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL rmw_wait got=%0b exp=0", wb_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL rmw_ready got=%0b exp=1", wb_ready); end
        checks++; if (wb_write !== 1'b0 || wb_write_reg !== 5'd0 || wb_write_data !== 32'd0 || retired_count !== 32'd0) begin failures++; $display("FAIL rmw_clear write=%0b reg=%0d data=%08h count=%0d exp all 0", wb_write, wb_write_reg, wb_write_data, retired_count); end
        wb_mem_data_valid = 1'b1; wb_memory_data = 32'h1111_2222;
        tick();
        drive_idle();
        checks++; if (wb_write !== 1'b0 || retired_count !== 32'd0) begin failures++; $display("FAIL rmw_dropped write=%0b count=%0d exp write=0 count=0", wb_write, retired_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_alu(5'(i + 1), 32'h0000_0100 + 32'(i), 1'b1);
            tick();
            checks++; if (wb_write !== 1'b1 || wb_write_reg !== 5'(i + 1) || wb_write_data !== 32'h0000_0100 + 32'(i)) begin failures++; $display("FAIL b2b_write i=%0d write=%0b reg=%0d data=%08h", i, wb_write, wb_write_reg, wb_write_data); end
            checks++; if (retired_count !== 32'(i + 1)) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, retired_count, i + 1); end
            checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, wb_ready); end
        end
        drive_idle();
        tick();
        checks++; if (wb_write !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", wb_write); end
    endtask

    task automatic test_wrap();
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        drive_alu(5'd3, 32'h0000_0033, 1'b1);
        tick();
        drive_idle();
        checks++; if (retired_count !== 32'd0) begin failures++; $display("FAIL wrap_count got=%08h exp=00000000", retired_count); end
        checks++; if (wb_write !== 1'b1 || wb_write_data !== 32'h0000_0033) begin failures++; $display("FAIL wrap_write write=%0b data=%08h exp 1/00000033", wb_write, wb_write_data); end
        drive_alu(5'd4, 32'h0000_0044, 1'b1);
        tick();
        drive_idle();
        checks++; if (retired_count !== 32'd1) begin failures++; $display("FAIL wrap_after got=%0d exp=1", retired_count); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_alu_write();
        test_r0_write();
        test_load_miss();
        test_extension();
        test_reset_mid_wait();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
